// File: rtl/parking_gate_scheduler_pkg.sv
// Shared types and default timing for the parking gate scheduler.
// Imported by the interface, the occupancy counter and the top-level FSM.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AUTH  = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } gate_state_e;

  typedef enum logic {
    ENTRY = 1'b0,
    EXIT  = 1'b1
  } lane_e;

  localparam int DEFAULT_CAPACITY    = 8;
  localparam int DEFAULT_AUTH_CYCLES = 16;
  localparam int DEFAULT_OPEN_CYCLES = 64;

  // Width that can hold the last value of either phase timer.
  function automatic int timer_width(input int auth_cycles, input int open_cycles);
    int longest;
    longest = (auth_cycles > open_cycles) ? auth_cycles : open_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Lane-sensor / actuator bundle between the car park front end and the scheduler.
// The master side drives sensor events; the slave side (scheduler) drives gate and status.
interface parking_gate_scheduler_if #(
  parameter int CAPACITY = parking_pkg::DEFAULT_CAPACITY
);
  localparam int CW = $clog2(CAPACITY + 1);

  logic          entry_req;
  logic          exit_req;
  logic          pass_ok;
  logic          gate_clear;
  logic          entry_grant;
  logic          exit_grant;
  logic          gate_open;
  logic          deny;
  logic          timeout_err;
  logic [CW-1:0] occupancy;
  logic          full;
  logic          empty;

  modport master (
    output entry_req, exit_req, pass_ok, gate_clear,
    input  entry_grant, exit_grant, gate_open, deny, timeout_err,
    input  occupancy, full, empty
  );

  modport slave (
    input  entry_req, exit_req, pass_ok, gate_clear,
    output entry_grant, exit_grant, gate_open, deny, timeout_err,
    output occupancy, full, empty
  );

endinterface

// File: rtl/parking_gate_scheduler_occupancy_counter.sv
// Saturating count of vehicles inside the lot, with full/empty flags decoded
// from the registered count so they move in the same cycle as the count.
module occupancy_counter #(
  parameter int CAPACITY = parking_pkg::DEFAULT_CAPACITY,
  localparam int CW      = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(CAPACITY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != FULL_COUNT)) begin
      count <= count + 1'b1;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/parking_gate_scheduler.sv
// Single barrier shared by entry and exit lanes: arbitrate, authenticate entries,
// hold the gate open until the car passes or the open window expires, then close.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEFAULT_CAPACITY,
  parameter int AUTH_CYCLES = DEFAULT_AUTH_CYCLES,
  parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  parking_gate_scheduler_if.slave  bus
);

  localparam int CW = $clog2(CAPACITY + 1);
  localparam int TW = timer_width(AUTH_CYCLES, OPEN_CYCLES);
  localparam logic [TW-1:0] AUTH_LAST = TW'(AUTH_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);

  gate_state_e   state, state_nxt;
  lane_e         cur_lane, cur_lane_nxt;
  lane_e         last_served, last_served_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    deny_hold, deny_hold_nxt;

  logic entry_grant_q, exit_grant_q, gate_open_q, deny_q, timeout_q;
  logic entry_grant_nxt, exit_grant_nxt, gate_open_nxt, deny_nxt, timeout_nxt;

  logic          inc, dec;
  logic          entry_ok, exit_ok;
  logic [CW-1:0] count;
  logic          is_full, is_empty;

  occupancy_counter #(.CAPACITY(CAPACITY)) u_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .count (count),
    .full  (is_full),
    .empty (is_empty)
  );

  assign entry_ok = bus.entry_req && !is_full;
  assign exit_ok  = bus.exit_req  && !is_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cur_lane      <= ENTRY;
      last_served   <= EXIT;
      timer         <= '0;
      deny_hold     <= '0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      gate_open_q   <= 1'b0;
      deny_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cur_lane      <= cur_lane_nxt;
      last_served   <= last_served_nxt;
      timer         <= timer_nxt;
      deny_hold     <= deny_hold_nxt;
      entry_grant_q <= entry_grant_nxt;
      exit_grant_q  <= exit_grant_nxt;
      gate_open_q   <= gate_open_nxt;
      deny_q        <= deny_nxt;
      timeout_q     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cur_lane_nxt    = cur_lane;
    last_served_nxt = last_served;
    timer_nxt       = timer;
    deny_hold_nxt   = 2'd0;
    deny_nxt        = 1'b0;
    timeout_nxt     = 1'b0;
    inc             = 1'b0;
    dec             = 1'b0;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        // A held refusal re-pulses deny only every fourth cycle.
        if (bus.entry_req && is_full) begin
          if (deny_hold == 2'd0) begin
            deny_nxt      = 1'b1;
            deny_hold_nxt = 2'd3;
          end else begin
            deny_hold_nxt = deny_hold - 2'd1;
          end
        end
        if (entry_ok && (!exit_ok || (last_served == EXIT))) begin
          state_nxt    = AUTH;
          cur_lane_nxt = ENTRY;
        end else if (exit_ok) begin
          state_nxt    = OPEN;
          cur_lane_nxt = EXIT;
        end
      end

      AUTH: begin
        if (bus.pass_ok) begin
          state_nxt = OPEN;
          timer_nxt = '0;
        end else if (timer == AUTH_LAST) begin
          deny_nxt        = 1'b1;
          last_served_nxt = ENTRY;
          state_nxt       = IDLE;
          timer_nxt       = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      OPEN: begin
        // The count moves on the same edge the gate starts closing.
        if (bus.gate_clear) begin
          inc       = (cur_lane == ENTRY);
          dec       = (cur_lane == EXIT);
          state_nxt = CLOSE;
          timer_nxt = '0;
        end else if (timer == OPEN_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = CLOSE;
          timer_nxt   = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      CLOSE: begin
        last_served_nxt = cur_lane;
        state_nxt       = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    entry_grant_nxt = (state_nxt == AUTH) ||
                      ((state_nxt == OPEN) && (cur_lane_nxt == ENTRY));
    exit_grant_nxt  = (state_nxt == OPEN) && (cur_lane_nxt == EXIT);
    gate_open_nxt   = (state_nxt == OPEN);
  end

  assign bus.entry_grant = entry_grant_q;
  assign bus.exit_grant  = exit_grant_q;
  assign bus.gate_open   = gate_open_q;
  assign bus.deny        = deny_q;
  assign bus.timeout_err = timeout_q;
  assign bus.occupancy   = count;
  assign bus.full        = is_full;
  assign bus.empty       = is_empty;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler: linear scenario with hand-computed
// expectations checked by immediate assertions one cycle after each causing edge.
module tb_parking_gate_scheduler;

  localparam int CW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic seen_a;
  logic seen_b;

  parking_gate_scheduler_if #(.CAPACITY(8)) bus ();

  parking_gate_scheduler #(
    .CAPACITY    (8),
    .AUTH_CYCLES (16),
    .OPEN_CYCLES (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CW-1:0] observed,
                           input logic [CW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Complete entry: grant, immediate password, immediate clear, back to IDLE.
  task automatic do_entry();
    bus.entry_req = 1'b1;
    step();
    bus.entry_req = 1'b0;
    bus.pass_ok   = 1'b1;
    step();
    bus.pass_ok    = 1'b0;
    bus.gate_clear = 1'b1;
    step();
    bus.gate_clear = 1'b0;
    step();
  endtask

  task automatic do_exit();
    bus.exit_req = 1'b1;
    step();
    bus.exit_req   = 1'b0;
    bus.gate_clear = 1'b1;
    step();
    bus.gate_clear = 1'b0;
    step();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b0;
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.pass_ok    = 1'b0;
    bus.gate_clear = 1'b0;
    step(3);
    check_bit("rst_gate_open", bus.gate_open, 1'b0);
    check_cnt("rst_occupancy", bus.occupancy, 4'd0);
    check_bit("rst_empty", bus.empty, 1'b1);
    check_bit("rst_full", bus.full, 1'b0);
    check_bit("rst_entry_grant", bus.entry_grant, 1'b0);
    check_bit("rst_deny", bus.deny, 1'b0);
    rst = 1'b1;
    step();

    // Stray pass_ok / gate_clear in IDLE must be ignored.
    bus.pass_ok    = 1'b1;
    bus.gate_clear = 1'b1;
    step();
    bus.pass_ok    = 1'b0;
    bus.gate_clear = 1'b0;
    check_bit("stray_gate_open", bus.gate_open, 1'b0);
    check_cnt("stray_occupancy", bus.occupancy, 4'd0);

    // Entry path with pass_ok three cycles after grant and clear five cycles later.
    bus.entry_req = 1'b1;
    step();
    bus.entry_req = 1'b0;
    check_bit("entry_grant", bus.entry_grant, 1'b1);
    check_bit("entry_auth_closed", bus.gate_open, 1'b0);
    step(2);
    bus.pass_ok = 1'b1;
    step();
    bus.pass_ok = 1'b0;
    check_bit("entry_gate_open", bus.gate_open, 1'b1);
    check_cnt("entry_occ_before", bus.occupancy, 4'd0);
    step(4);
    bus.gate_clear = 1'b1;
    step();
    bus.gate_clear = 1'b0;
    check_bit("entry_gate_closed", bus.gate_open, 1'b0);
    check_cnt("entry_occ_after", bus.occupancy, 4'd1);
    check_bit("entry_not_empty", bus.empty, 1'b0);
    step();
    check_bit("entry_close_grant", bus.entry_grant, 1'b0);

    // Build occupancy 3 with last_served = EXIT, then raise both lanes.
    do_entry();
    do_entry();
    do_entry();
    do_exit();
    check_cnt("setup_occ3", bus.occupancy, 4'd3);
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    step();
    bus.entry_req = 1'b0;
    check_bit("rr_entry_first", bus.entry_grant, 1'b1);
    check_bit("rr_exit_waits", bus.exit_grant, 1'b0);
    bus.pass_ok = 1'b1;
    step();
    bus.pass_ok    = 1'b0;
    bus.gate_clear = 1'b1;
    step();
    bus.gate_clear = 1'b0;
    check_cnt("rr_occ4", bus.occupancy, 4'd4);
    step(2);
    bus.exit_req = 1'b0;
    check_bit("rr_exit_second", bus.exit_grant, 1'b1);
    check_bit("rr_exit_open", bus.gate_open, 1'b1);
    bus.gate_clear = 1'b1;
    step();
    bus.gate_clear = 1'b0;
    check_cnt("rr_final_occ", bus.occupancy, 4'd3);
    step();

    // Auth timeout: sixteen cycles in AUTH with no password.
    bus.entry_req = 1'b1;
    step();
    bus.entry_req = 1'b0;
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen_a |= bus.deny;
      seen_b |= bus.gate_open;
    end
    check_bit("auth_no_early_deny", seen_a, 1'b0);
    check_bit("auth_still_granted", bus.entry_grant, 1'b1);
    step();
    check_bit("auth_deny_pulse", bus.deny, 1'b1);
    check_bit("auth_grant_drop", bus.entry_grant, 1'b0);
    seen_b |= bus.gate_open;
    step();
    check_bit("auth_deny_single", bus.deny, 1'b0);
    check_bit("auth_never_open", seen_b, 1'b0);
    check_cnt("auth_occ", bus.occupancy, 4'd3);

    // Open timeout on an exit with no gate_clear.
    bus.exit_req = 1'b1;
    step();
    bus.exit_req = 1'b0;
    check_bit("otmo_exit_grant", bus.exit_grant, 1'b1);
    step(63);
    check_bit("otmo_still_open", bus.gate_open, 1'b1);
    check_bit("otmo_no_early", bus.timeout_err, 1'b0);
    step();
    check_bit("otmo_pulse", bus.timeout_err, 1'b1);
    check_bit("otmo_closed", bus.gate_open, 1'b0);
    check_cnt("otmo_occ", bus.occupancy, 4'd3);
    step();
    check_bit("otmo_single", bus.timeout_err, 1'b0);

    // Fill to capacity, then hold entry_req against a full lot.
    for (int i = 0; i < 5; i++) do_entry();
    check_cnt("fill_occ8", bus.occupancy, 4'd8);
    check_bit("fill_full", bus.full, 1'b1);
    bus.entry_req = 1'b1;
    seen_a = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      check_bit($sformatf("full_deny_%0d", i), bus.deny, (i % 4) == 1);
      seen_a |= bus.entry_grant;
    end
    bus.entry_req = 1'b0;
    check_bit("full_no_grant", seen_a, 1'b0);
    step();
    do_exit();
    check_cnt("full_exit_occ7", bus.occupancy, 4'd7);
    check_bit("full_cleared", bus.full, 1'b0);
    do_entry();
    check_cnt("refill_occ8", bus.occupancy, 4'd8);

    // Reset asserted while the gate is open for an exit.
    bus.exit_req = 1'b1;
    step();
    bus.exit_req = 1'b0;
    check_bit("rstmid_open", bus.gate_open, 1'b1);
    step();
    rst = 1'b0;
    #1;
    check_bit("rstmid_async_gate", bus.gate_open, 1'b0);
    check_cnt("rstmid_async_occ", bus.occupancy, 4'd0);
    step(2);
    rst = 1'b1;
    step();
    check_bit("rstmid_idle_open", bus.gate_open, 1'b0);
    check_bit("rstmid_idle_grant", bus.exit_grant, 1'b0);
    check_bit("rstmid_empty", bus.empty, 1'b1);

    // Exit request on an empty lot is ignored silently.
    bus.exit_req = 1'b1;
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen_a |= bus.exit_grant | bus.gate_open;
      seen_b |= bus.deny;
    end
    bus.exit_req = 1'b0;
    check_bit("empty_exit_no_grant", seen_a, 1'b0);
    check_bit("empty_exit_no_deny", seen_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
